mem_io_ctrl: RTL and testbench
==============================

// Module: mem_io_ctrl
// PURPOSE
//  Bus controller between the cpu memory port (mem_cmd/mem_addr) and the RAM plus board I/O.
//  Decodes each CPU access to one of three targets: RAM (mem_addr[8]=0), the switch port or the LED port.
//  Sequences the RAM's one-cycle registered read and tells the CPU when each access completes (mem_ready).
//  Replaces the ad-hoc tri-state read_data mux with a registered, single-driver read path.
// PARAMETERS
//  DW        16      data width of CPU, RAM and read_data
//  RAM_AW    8       RAM word address width; RAM window is mem_addr[8]==0
//  LED_ADDR  9'h100  write-only LED register address
//  SW_ADDR   9'h140  read-only switch port address
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       asynchronous reset, active-high
//  mem_cmd      in   2       command: 00 NONE, 01 READ, 10 WRITE, 11 illegal
//  mem_addr     in   9       word address from the CPU
//  write_data   in   DW      CPU store data
//  read_data    out  DW      load data; valid only while mem_ready=1
//  mem_ready    out  1       one-cycle pulse: access complete
//  bus_err      out  1       sticky error flag
//  ram_addr     out  RAM_AW  RAM word address
//  ram_write    out  1       RAM write enable
//  ram_din      out  DW      RAM write data
//  ram_dout     in   DW      RAM read data (registered; valid 1 cycle after ram_addr)
//  sw_in        in   8       raw board switches (asynchronous)
//  ledr         out  8       LED register
// BEHAVIOUR
//  Reset (async): state=IDLE; read_data=0; mem_ready=0; bus_err=0; ram_write=0; ram_addr=0; ram_din=0;
//   ledr=0; switch synchronizer=0. If reset asserts mid-access, that access is dropped: no RAM write, no ready.
//  sw_in: 2-flop synchronizer (sw_sync). A read of SW_ADDR returns the sw_sync value at the sampling edge.
//  Latching: on the IDLE edge that accepts a command, mem_addr and write_data go into addr_q and wdata_q.
//   ram_addr=addr_q[RAM_AW-1:0] and ram_din=wdata_q are registered outputs.
//  FSM states: IDLE, RD_WAIT, WR, RESP.
//   IDLE + NONE                 -> IDLE
//   IDLE + READ,  addr[8]=0     -> RD_WAIT
//   IDLE + WRITE, addr[8]=0     -> WR
//   IDLE + READ,  SW_ADDR       -> RESP; read_data <= {0,sw_sync}
//   IDLE + WRITE, LED_ADDR      -> RESP; ledr <= write_data[7:0]
//   IDLE + other (unmapped addr[8]=1, READ of LED_ADDR, WRITE of SW_ADDR, cmd 11)
//                               -> RESP; read_data <= 0; bus_err <= 1
//   RD_WAIT -> RESP; read_data <= ram_dout
//   WR      -> RESP; ram_write=1 for exactly this one cycle
//   RESP    -> IDLE; mem_ready=1 for exactly this one cycle
//  Latency (accept edge to the edge where the CPU samples mem_ready):
//   RAM read 3 edges; RAM write 3 edges; I/O or error 2 edges.
//  CPU rule: hold mem_cmd/mem_addr/write_data until it samples mem_ready=1, then present the next command
//   on that same edge. IDLE samples it on the following edge, so a command executes once; no back-to-back
//   overlap.
//  read_data holds its value outside RESP. It returns 0 after a write or error access.
//  bus_err clears only on reset.
//  ram_write is never 1 outside WR.
//  Address wrap: none. The RAM uses addr[7:0] only when addr[8]=0.
// TESTING
//  1. Reset, WRITE 9'h005 <- 16'hBEEF, then READ 9'h005:
//     -> ram_write=1 for one cycle with ram_addr=8'h05, ram_din=16'hBEEF;
//     -> read returns 16'hBEEF with mem_ready 3 edges after accept.
//  2. sw_in=8'hA5 held >=2 cycles, READ 9'h140 -> read_data=16'h00A5, mem_ready 2 edges after accept.
//  3. WRITE 9'h100 <- 16'h12C3 -> ledr=8'hC3 at the RESP edge; no ram_write pulse; bus_err stays 0.
//  4. READ 9'h1FF, then WRITE 9'h140:
//     -> each completes with mem_ready and read_data=0;
//     -> bus_err=1 and stays 1 through later good accesses until reset.
//  5. Back-to-back: READ 9'h010, then WRITE 9'h011, each issued on the ready edge of the previous
//     -> each executes exactly once; one ram_write pulse total.
//  6. Reset asserted while in WR (mid-write) -> ram_write drops immediately; no mem_ready; state=IDLE;
//     -> RAM word unchanged on read-back.

Source files
------------

// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: bus controller between the CPU memory port, a RAM with a
// registered read port, an LED output register and a switch input port.
// Every CPU access is decoded once, sequenced through a small FSM, and
// completed with a one-cycle mem_ready pulse. read_data is a single
// registered driver.
module mem_io_ctrl #(
    parameter int         DW       = 16,
    parameter int         RAM_AW   = 8,
    parameter logic [8:0] LED_ADDR = 9'h100,
    parameter logic [8:0] SW_ADDR  = 9'h140
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        mem_cmd,
    input  logic [8:0]        mem_addr,
    input  logic [DW-1:0]     write_data,
    output logic [DW-1:0]     read_data,
    output logic              mem_ready,
    output logic              bus_err,
    output logic [RAM_AW-1:0] ram_addr,
    output logic              ram_write,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,
    input  logic [7:0]        sw_in,
    output logic [7:0]        ledr
);

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR      = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_reg;
    logic [RAM_AW-1:0]   addr_q;
    logic [DW-1:0]       wdata_q;
    logic                ram_rd_q;   // current access is a RAM read
    logic [7:0]          sw_meta;
    logic [7:0]          sw_sync;

    // Address decode of the command presented by the CPU.
    logic is_ram;
    logic is_sw;
    logic is_led;
    assign is_ram = ~mem_addr[8];
    assign is_sw  = (mem_addr == SW_ADDR);
    assign is_led = (mem_addr == LED_ADDR);

    // The RAM port is driven straight from the latched access registers.
    assign ram_addr = addr_q;
    assign ram_din  = wdata_q;

    // Two-flop synchronizer for the asynchronous board switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta <= 8'h00;
            sw_sync <= 8'h00;
        end else begin
            sw_meta <= sw_in;
            sw_sync <= sw_meta;
        end
    end

    // Access sequencer: decode on accept, wait for RAM, respond with mem_ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            ram_rd_q  <= 1'b0;
            read_data <= '0;
            mem_ready <= 1'b0;
            bus_err   <= 1'b0;
            ram_write <= 1'b0;
            ledr      <= 8'h00;
        end else begin
            mem_ready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // While mem_ready is high the CPU still presents the
                    // finished command; it switches on this edge, so ignore it.
                    if (!mem_ready && mem_cmd != CMD_NONE) begin
                        addr_q   <= mem_addr[RAM_AW-1:0];
                        wdata_q  <= write_data;
                        ram_rd_q <= 1'b0;
                        if (mem_cmd == CMD_READ && is_ram) begin
                            ram_rd_q  <= 1'b1;
                            state_reg <= RD_WAIT;
                        end else if (mem_cmd == CMD_WRITE && is_ram) begin
                            read_data <= '0;
                            ram_write <= 1'b1;
                            state_reg <= WR;
                        end else if (mem_cmd == CMD_READ && is_sw) begin
                            read_data <= {{(DW-8){1'b0}}, sw_sync};
                            state_reg <= RESP;
                        end else if (mem_cmd == CMD_WRITE && is_led) begin
                            read_data <= '0;
                            ledr      <= write_data[7:0];
                            state_reg <= RESP;
                        end else begin
                            read_data <= '0;
                            bus_err   <= 1'b1;
                            state_reg <= RESP;
                        end
                    end
                end
                RD_WAIT: begin
                    // ram_addr became valid on the accept edge; the RAM
                    // registers it on this edge, so data is usable next edge.
                    state_reg <= RESP;
                end
                WR: begin
                    ram_write <= 1'b0;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (ram_rd_q) begin
                        read_data <= ram_dout;
                    end
                    ram_rd_q  <= 1'b0;
                    mem_ready <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed testbench for mem_io_ctrl with a behavioural registered-read RAM.
module tb_mem_io_ctrl;

    localparam int DW = 16;

    logic          clk;
    logic          reset;
    logic [1:0]    mem_cmd;
    logic [8:0]    mem_addr;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          mem_ready;
    logic          bus_err;
    logic [7:0]    ram_addr;
    logic          ram_write;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    logic [7:0]    sw_in;
    logic [7:0]    ledr;

    int errors = 0;
    int checks = 0;

    int         wr_pulses = 0;
    logic [7:0] last_waddr = 8'h00;
    logic [15:0] last_wdin = 16'h0000;

    logic [DW-1:0] ram_mem [0:255];

    mem_io_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .mem_cmd    (mem_cmd),
        .mem_addr   (mem_addr),
        .write_data (write_data),
        .read_data  (read_data),
        .mem_ready  (mem_ready),
        .bus_err    (bus_err),
        .ram_addr   (ram_addr),
        .ram_write  (ram_write),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout),
        .sw_in      (sw_in),
        .ledr       (ledr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous write, registered read.
    always @(posedge clk) begin
        if (ram_write) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    // Count cycles with ram_write high and record the write port contents.
    always @(negedge clk) begin
        if (ram_write) begin
            wr_pulses  = wr_pulses + 1;
            last_waddr = ram_addr;
            last_wdin  = ram_din;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // One CPU access; called at posedge+1. Returns the data seen while
    // mem_ready=1 and the number of edges from accept to the sampling edge.
    task automatic access(input logic [1:0] cmd, input logic [8:0] addr,
                          input logic [15:0] wd, output logic [15:0] rd,
                          output int lat);
        mem_cmd    = cmd;
        mem_addr   = addr;
        write_data = wd;
        rd  = 16'hxxxx;
        lat = 99;
        @(posedge clk);              // accept edge
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mem_ready) begin
                lat = k;
                rd  = read_data;
                break;
            end
        end
        @(posedge clk);              // CPU samples mem_ready here
        #1;
        mem_cmd = 2'b00;
        check("ready_one_cycle", {31'd0, mem_ready}, 32'd0);
        $display("access cmd=%b addr=%h wd=%h -> rd=%h lat=%0d", cmd, addr, wd, rd, lat);
    endtask

    logic [15:0] rd;
    int          lat;
    int          pulses0;
    int          stray;

    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = 16'h0000;
        reset      = 1'b1;
        mem_cmd    = 2'b00;
        mem_addr   = 9'h000;
        write_data = 16'h0000;
        sw_in      = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_read_data", {16'd0, read_data}, 32'd0);
        check("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_bus_err",   {31'd0, bus_err},   32'd0);
        check("rst_ram_write", {31'd0, ram_write}, 32'd0);
        check("rst_ram_addr",  {24'd0, ram_addr},  32'd0);
        check("rst_ram_din",   {16'd0, ram_din},   32'd0);
        check("rst_ledr",      {24'd0, ledr},      32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // 1: RAM write then read-back
        pulses0 = wr_pulses;
        access(2'b10, 9'h005, 16'hBEEF, rd, lat);
        check("t1_wr_lat",    lat, 3);
        check("t1_wr_pulses", wr_pulses - pulses0, 1);
        check("t1_wr_addr",   {24'd0, last_waddr}, 32'h05);
        check("t1_wr_din",    {16'd0, last_wdin},  32'hBEEF);
        check("t1_wr_rdata",  {16'd0, rd},         32'h0);
        access(2'b01, 9'h005, 16'h0000, rd, lat);
        check("t1_rd_lat",    lat, 3);
        check("t1_rd_data",   {16'd0, rd}, 32'hBEEF);

        // 2: switch port read
        sw_in = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        access(2'b01, 9'h140, 16'h0000, rd, lat);
        check("t2_sw_lat",  lat, 2);
        check("t2_sw_data", {16'd0, rd}, 32'h00A5);

        // 3: LED write
        pulses0 = wr_pulses;
        access(2'b10, 9'h100, 16'h12C3, rd, lat);
        check("t3_led_lat",    lat, 2);
        check("t3_ledr",       {24'd0, ledr}, 32'hC3);
        check("t3_no_ramwr",   wr_pulses - pulses0, 0);
        check("t3_bus_err",    {31'd0, bus_err}, 32'd0);
        check("t3_rdata_zero", {16'd0, rd}, 32'h0);

        // 4: errors, then bus_err stays sticky
        access(2'b01, 9'h1FF, 16'h0000, rd, lat);
        check("t4_unmapped_lat",  lat, 2);
        check("t4_unmapped_data", {16'd0, rd}, 32'h0);
        check("t4_err_set",       {31'd0, bus_err}, 32'd1);
        access(2'b01, 9'h005, 16'h0000, rd, lat);
        check("t4_good_rd",       {16'd0, rd}, 32'hBEEF);
        pulses0 = wr_pulses;
        access(2'b10, 9'h140, 16'hFFFF, rd, lat);
        check("t4_wrsw_lat",      lat, 2);
        check("t4_wrsw_data",     {16'd0, rd}, 32'h0);
        check("t4_wrsw_noramwr",  wr_pulses - pulses0, 0);
        check("t4_ledr_kept",     {24'd0, ledr}, 32'hC3);
        access(2'b11, 9'h005, 16'h0000, rd, lat);
        check("t4_cmd11_data",    {16'd0, rd}, 32'h0);
        check("t4_err_sticky",    {31'd0, bus_err}, 32'd1);

        // 5: back-to-back accesses on the ready edge
        access(2'b10, 9'h010, 16'h3C3C, rd, lat);
        pulses0 = wr_pulses;
        access(2'b01, 9'h010, 16'h0000, rd, lat);
        check("t5_rd_data", {16'd0, rd}, 32'h3C3C);
        check("t5_rd_lat",  lat, 3);
        access(2'b10, 9'h011, 16'h7777, rd, lat);
        check("t5_wr_lat",    lat, 3);
        check("t5_one_pulse", wr_pulses - pulses0, 1);
        check("t5_wr_addr",   {24'd0, last_waddr}, 32'h11);
        access(2'b01, 9'h011, 16'h0000, rd, lat);
        check("t5_readback",  {16'd0, rd}, 32'h7777);
        check("t5_err_still", {31'd0, bus_err}, 32'd1);

        // 6: reset in the middle of a RAM write
        access(2'b10, 9'h020, 16'hAAAA, rd, lat);
        pulses0    = wr_pulses;
        mem_cmd    = 2'b10;
        mem_addr   = 9'h020;
        write_data = 16'h5555;
        @(posedge clk);               // accept -> WR
        #2;
        check("t6_in_wr", {31'd0, ram_write}, 32'd1);
        reset = 1'b1;
        #1;
        check("t6_ramwr_drop", {31'd0, ram_write}, 32'd0);
        check("t6_no_ready",   {31'd0, mem_ready}, 32'd0);
        check("t6_err_clr",    {31'd0, bus_err},   32'd0);
        mem_cmd = 2'b00;
        #3;
        reset = 1'b0;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_ready || ram_write) stray = stray + 1;
        end
        check("t6_no_stray",   stray, 0);
        check("t6_no_pulse",   wr_pulses - pulses0, 0);
        @(posedge clk); #1;
        access(2'b01, 9'h020, 16'h0000, rd, lat);
        check("t6_ram_kept",   {16'd0, rd}, 32'hAAAA);
        check("t6_rd_lat",     lat, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
